// File: rtl/hex_value_display.sv
// hex_value_display: turns the HPS value/mode words into six registered 7-segment digits,
// either decimal (sequential double-dabble) or hexadecimal, with blanking and overflow dash.
module hex_value_display #(
  parameter int DATA_W      = 20,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] value_in,
  input  logic [15:0] mode_in,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        busy,
  output logic        overflow
);

  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [31:0]      DEC_MAX  = 32'd999999;
  localparam logic [6:0]       LIT_DASH = 7'h40;
  localparam logic [6:0]       LIT_NONE = 7'h00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_ENC   = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [31:0]       val_q_r;
  logic [7:0]        mode_q_r;
  logic              pending_r;
  logic [23:0]       bcd_r;
  logic [DATA_W-1:0] sr_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              change_s;
  logic [23:0]       bcd_adj_s;
  logic [31:0]       val_lo_s;
  logic [31:0]       val_hi_s;
  logic              ovf_s;
  logic              lead_s;
  logic [3:0]        dig_s [6];
  logic [5:0]        blank_s;
  logic [6:0]        seg_s [6];
  logic              unused_s;

  // Lit-segment pattern {g,f,e,d,c,b,a} for one hex digit; b and d are lowercase glyphs.
  function automatic logic [6:0] seg_glyph(input logic [3:0] digit);
    logic [6:0] lit;
    case (digit)
      4'h0: lit = 7'h3F;
      4'h1: lit = 7'h06;
      4'h2: lit = 7'h5B;
      4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66;
      4'h5: lit = 7'h6D;
      4'h6: lit = 7'h7D;
      4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F;
      4'h9: lit = 7'h6F;
      4'hA: lit = 7'h77;
      4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39;
      4'hD: lit = 7'h5E;
      4'hE: lit = 7'h79;
      4'hF: lit = 7'h71;
      default: lit = 7'h00;
    endcase
    return lit;
  endfunction

  // Map a lit-segment pattern onto the pin polarity of the board.
  function automatic logic [6:0] seg_pins(input logic [6:0] lit);
    return SEG_ACT_LOW ? ~lit : lit;
  endfunction

  // Change detect and the per-iteration BCD add-3 correction.
  always_comb begin
    change_s  = (value_in != val_q_r) | (mode_in[7:0] != mode_q_r) | pending_r;
    bcd_adj_s = bcd_r;
    for (int i = 0; i < 6; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) begin
        bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj_s[4*i +: 4] = bcd_r[4*i +: 4];
      end
    end
    unused_s = ^{mode_in[15:8], bcd_adj_s[23]};
  end

  // Digit selection, blanking and segment encoding consumed by the ENC edge.
  always_comb begin
    val_lo_s = 32'(val_q_r[DATA_W-1:0]);
    val_hi_s = val_q_r >> DATA_W;
    ovf_s    = mode_q_r[0] && ((val_hi_s != 32'd0) || (val_lo_s > DEC_MAX));
    for (int i = 0; i < 6; i++) begin
      dig_s[i] = mode_q_r[0] ? bcd_r[4*i +: 4] : val_q_r[4*i +: 4];
    end
    lead_s     = mode_q_r[1];
    blank_s[0] = mode_q_r[2];
    for (int i = 5; i >= 1; i--) begin
      if (lead_s && (dig_s[i] == 4'd0)) begin
        blank_s[i] = 1'b1;
      end else begin
        lead_s     = 1'b0;
        blank_s[i] = mode_q_r[2+i];
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (ovf_s) begin
        seg_s[i] = seg_pins(LIT_DASH);
      end else if (blank_s[i]) begin
        seg_s[i] = seg_pins(LIT_NONE);
      end else begin
        seg_s[i] = seg_pins(seg_glyph(dig_s[i]));
      end
    end
  end

  // Next-state logic of the conversion sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (change_s) begin
          state_s = S_LOAD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (mode_in[0]) begin
          state_s = S_SHIFT;
        end else begin
          state_s = S_ENC;
        end
      end
      S_SHIFT: begin
        if (cnt_r == CNT_LAST) begin
          state_s = S_ENC;
        end else begin
          state_s = S_SHIFT;
        end
      end
      S_ENC:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand shadows, double-dabble datapath and the atomically updated outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      val_q_r   <= 32'd0;
      mode_q_r  <= 8'd0;
      pending_r <= 1'b1;
      bcd_r     <= 24'd0;
      sr_r      <= '0;
      cnt_r     <= '0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
      hex0      <= seg_pins(LIT_NONE);
      hex1      <= seg_pins(LIT_NONE);
      hex2      <= seg_pins(LIT_NONE);
      hex3      <= seg_pins(LIT_NONE);
      hex4      <= seg_pins(LIT_NONE);
      hex5      <= seg_pins(LIT_NONE);
    end else begin
      case (state_r)
        S_IDLE: begin
          if (change_s) begin
            busy <= 1'b1;
          end
        end
        S_LOAD: begin
          val_q_r   <= value_in;
          mode_q_r  <= mode_in[7:0];
          pending_r <= 1'b0;
          busy      <= 1'b1;
          bcd_r     <= 24'd0;
          sr_r      <= value_in[DATA_W-1:0];
          cnt_r     <= '0;
        end
        S_SHIFT: begin
          bcd_r <= {bcd_adj_s[22:0], sr_r[DATA_W-1]};
          sr_r  <= sr_r << 1;
          if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
          end
        end
        S_ENC: begin
          hex0     <= seg_s[0];
          hex1     <= seg_s[1];
          hex2     <= seg_s[2];
          hex3     <= seg_s[3];
          hex4     <= seg_s[4];
          hex5     <= seg_s[5];
          overflow <= ovf_s;
          busy     <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
